// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: 16x oversampled mid-bit sampling, valid/ready byte output, framing/overrun flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_deframer #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [3:0]    SAMP_MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    SAMP_END = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t        state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_bad_q, par_bad_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          parity_err_q, parity_err_d;
    logic          busy_q;
    logic          tick_s;
    logic          sample_end_s;

    assign tick_s       = (tick_cnt_q == DIV_M1);
    assign sample_end_s = tick_s && (samp_cnt_q == SAMP_END);

    // Next-state, counter and output-pulse logic.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_s ? {CW{1'b0}} : tick_cnt_q + CW'(1);
        samp_cnt_d   = tick_s ? samp_cnt_q + 4'd1 : samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_bad_d    = par_bad_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        parity_err_d = 1'b0;

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = {CW{1'b0}};
                samp_cnt_d = samp_cnt_q;
                if (!rx_s_q) begin
                    state_d    = S_START;
                    samp_cnt_d = 4'd0;
                    par_bad_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && (samp_cnt_q == SAMP_MID)) begin
                    // A start bit that is high again at mid-bit is treated as line noise.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        samp_cnt_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (sample_end_s) begin
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        samp_cnt_d = 4'd0;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_end_s) begin
                    state_d    = S_STOP;
                    samp_cnt_d = 4'd0;
                    if (rx_s_q != even_parity(shreg_q)) begin
                        parity_err_d = 1'b1;
                        par_bad_d    = 1'b1;
                    end else begin
                        par_bad_d = 1'b0;
                    end
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (sample_end_s) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        if (par_bad_q) begin
                            rx_data_d = rx_data_q;
                        end else if (!rx_valid_q || rx_ready_i) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                        samp_cnt_d  = 4'd0;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line releases so a break cannot look like new start bits.
                tick_cnt_d = {CW{1'b0}};
                samp_cnt_d = samp_cnt_q;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = {CW{1'b0}};
                samp_cnt_d = 4'd0;
            end
        endcase
    end

    // State, synchronizer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            tick_cnt_q   <= {CW{1'b0}};
            samp_cnt_q   <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'h00;
            par_bad_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= rx_i;
            rx_s_q       <= sync1_q;
            tick_cnt_q   <= tick_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign parity_err_o = parity_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: random bytes against a frame-level reference model.
// Runs with a reduced clock so each bit is 160 clk (DIV = 10); a bit period of 161 clk adds slight drift.
module tb_uart_rx_deframer;

    localparam int CLK_FREQ = 1536000;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int BITCLK   = 161;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    uart_rx_deframer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk(clk), .nrst(nrst), .rx_i(rx), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .frame_err_o(frame_err), .overrun_o(overrun),
        .parity_err_o(parity_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observed behaviour
    logic [7:0] got_q[$];
    int fe_cnt, ov_cnt, pe_cnt;
    bit busy_seen;

    // reference model state
    logic [7:0] exp_q[$];
    int exp_fe, exp_ov, exp_pe;
    bit m_full;
    logic [7:0] m_hold;

    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (parity_err) pe_cnt++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        got_q.delete(); exp_q.delete();
        fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; busy_seen = 1'b0;
        exp_fe = 0; exp_ov = 0; exp_pe = 0;
    endtask

    // Frame-level model: what the consumer should see for one frame given a constant ready level.
    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                                        input bit ready);
        if (!par_ok) exp_pe++;
        if (!stop_ok) exp_fe++;
        else if (par_ok) begin
            if (ready) exp_q.push_back(b);
            else if (!m_full) begin m_full = 1'b1; m_hold = b; end
            else exp_ov++;
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        rx = 1'b0; tick(BITCLK);
        for (int i = 0; i < 8; i++) begin rx = b[i]; tick(BITCLK); end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip; tick(BITCLK);
`endif
        rx = stop_v; tick(BITCLK);
    endtask

    task automatic test_reset();
        nrst = 1'b0; rx = 1'b1; rx_ready = 1'b0;
        tick(5);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b%b%b exp 000", frame_err, overrun, parity_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        nrst = 1'b1; m_full = 1'b0; m_hold = 8'h00;
        tick(20);
    endtask

    task automatic test_single_hold();
        clear_all(); rx_ready = 1'b0;
        send_frame(8'h53, 1'b1, 1'b0);
        model_frame(8'h53, 1'b1, 1'b1, 1'b0);
        tick(20);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rx_valid); end
        checks++; if (rx_data !== m_hold) begin errors++; $display("FAIL single_data got %h exp %h", rx_data, m_hold); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
        tick(50);
        checks++; if (rx_valid !== 1'b1 || rx_data !== m_hold) begin
            errors++; $display("FAIL single_hold got %b/%h exp 1/%h", rx_valid, rx_data, m_hold); end
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0; m_full = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", rx_valid); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'h53) begin
            errors++; $display("FAIL single_accept got %0d bytes exp 1 byte 53", got_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        clear_all(); rx_ready = 1'b1;
        bytes = '{8'h53, 8'h6E, 8'h61, 8'h70};
        for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom_range(0, 255)));
        foreach (bytes[i]) begin
            send_frame(bytes[i], 1'b1, 1'b0);
            model_frame(bytes[i], 1'b1, 1'b1, 1'b1);
        end
        tick(20);
        checks++; if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                checks++; if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (fe_cnt != exp_fe || ov_cnt != exp_ov) begin
            errors++; $display("FAIL b2b_errs got fe=%0d ov=%0d exp fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov); end
    endtask

    task automatic test_glitch();
        clear_all(); rx_ready = 1'b1;
        rx = 1'b0; tick(40); rx = 1'b1;
        tick(3 * BITCLK);
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b exp 1", busy_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
        checks++; if (got_q.size() != 0 || rx_valid !== 1'b0 || fe_cnt != 0 || ov_cnt != 0) begin
            errors++; $display("FAIL glitch_quiet got n=%0d v=%b fe=%0d ov=%0d exp 0", got_q.size(), rx_valid, fe_cnt, ov_cnt); end
    endtask

    task automatic test_frame_err();
        clear_all(); rx_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0);
        model_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        tick(400);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_wait_high got %b exp 1", busy); end
        checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL fe_count got %0d exp %0d", fe_cnt, exp_fe); end
        checks++; if (got_q.size() != 0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL fe_novalid got n=%0d v=%b exp 0", got_q.size(), rx_valid); end
        rx = 1'b1; tick(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_release got %b exp 0", busy); end
        send_frame(8'h3C, 1'b1, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        tick(20);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0] || fe_cnt != exp_fe) begin
            errors++; $display("FAIL fe_recover got n=%0d fe=%0d exp n=1 byte %h fe=%0d", got_q.size(), fe_cnt, exp_q[0], exp_fe); end
    endtask

    task automatic test_overrun_reset();
        logic [7:0] a, b, c;
        clear_all(); rx_ready = 1'b0; m_full = 1'b0;
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        send_frame(a, 1'b1, 1'b0); model_frame(a, 1'b1, 1'b1, 1'b0);
        send_frame(b, 1'b1, 1'b0); model_frame(b, 1'b1, 1'b1, 1'b0);
        tick(10);
        checks++; if (ov_cnt != exp_ov) begin errors++; $display("FAIL ovr_count got %0d exp %0d", ov_cnt, exp_ov); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== m_hold) begin
            errors++; $display("FAIL ovr_hold got %b/%h exp 1/%h", rx_valid, rx_data, m_hold); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL ovr_fe got %0d exp 0", fe_cnt); end
        // abandon a third frame part-way through with reset
        c = 8'($urandom_range(0, 255));
        rx = 1'b0; tick(BITCLK);
        for (int i = 0; i < 3; i++) begin rx = c[i]; tick(BITCLK); end
        rx = 1'b1; nrst = 1'b0; tick(3);
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset got v=%b d=%h b=%b exp 0/00/0", rx_valid, rx_data, busy); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
            errors++; $display("FAIL midreset_err got %b%b%b exp 000", frame_err, overrun, parity_err); end
        nrst = 1'b1; m_full = 1'b0;
        tick(BITCLK);
        clear_all(); rx_ready = 1'b1;
        c = 8'($urandom_range(0, 255));
        send_frame(c, 1'b1, 1'b0); model_frame(c, 1'b1, 1'b1, 1'b1);
        tick(20);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0] || fe_cnt != 0 || ov_cnt != 0) begin
            errors++; $display("FAIL postreset got n=%0d fe=%0d ov=%0d exp byte %h", got_q.size(), fe_cnt, ov_cnt, exp_q[0]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_all(); rx_ready = 1'b1;
        send_frame(8'h53, 1'b1, 1'b0); model_frame(8'h53, 1'b1, 1'b1, 1'b1);
        send_frame(8'h53, 1'b1, 1'b1); model_frame(8'h53, 1'b1, 1'b0, 1'b1);
        tick(20);
        checks++; if (pe_cnt != exp_pe) begin errors++; $display("FAIL par_count got %0d exp %0d", pe_cnt, exp_pe); end
        checks++; if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL par_data got n=%0d exp n=%0d byte 53", got_q.size(), exp_q.size()); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL par_fe got %0d exp 0", fe_cnt); end
    endtask
`endif

    initial begin
        clear_all();
        test_reset();
        test_single_hold();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
